// File: rtl/plot_arbiter.sv
// Plotter arbiter: grants one of N_REQ requesters, pulses plot_start,
// waits for plot_done or a timeout, then pulses req_done to the owner.
// Ports: clk, reset (async active-low), req[N_REQ], plot_done in;
//        grant[N_REQ], plot_start, req_done[N_REQ], busy, timeout_err out.
// Config: define PLOT_ARB_RR_EN for round-robin, else fixed priority.
module plot_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 76800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             plot_done,
  output logic [N_REQ-1:0] grant,
  output logic             plot_start,
  output logic [N_REQ-1:0] req_done,
  output logic             busy,
  output logic             timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2,
    S_REL   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N_REQ-1:0] r_grant;
  logic             r_plot_start;
  logic [N_REQ-1:0] r_req_done;
  logic             r_busy;
  logic             r_tmo_err;
  logic [CW-1:0]    r_cnt;

  logic [N_REQ-1:0] w_win_oh;
  logic [PW-1:0]    w_win_idx;
  logic             w_found;
  logic             w_tmo;
  logic             w_take;

`ifdef PLOT_ARB_RR_EN
  logic [PW-1:0]    r_ptr;
`endif

  // Winner selection
  always_comb begin
    w_win_idx = '0;
    w_found   = 1'b0;
`ifdef PLOT_ARB_RR_EN
    // Search starts one past the last winner and wraps.
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % N_REQ]) begin
        w_found   = 1'b1;
        w_win_idx = PW'((int'(r_ptr) + k) % N_REQ);
      end
    end
`else
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[i]) begin
        w_found   = 1'b1;
        w_win_idx = PW'(i);
      end
    end
`endif
    w_win_oh = N_REQ'(w_found) << w_win_idx;
  end

  assign w_take = (r_state == S_IDLE) && w_found;

  // Next state
  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_found) w_next = S_GRANT;
      S_GRANT: w_next = S_BUSY;
      S_BUSY: begin
        // A done pulse on the terminal cycle beats the timeout.
        if (plot_done) begin
          w_next = S_REL;
        end else if (r_cnt == TERM) begin
          w_next = S_REL;
          w_tmo  = 1'b1;
        end
      end
      S_REL:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_plot_start <= 1'b0;
      r_req_done   <= '0;
      r_busy       <= 1'b0;
      r_tmo_err    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_next;
      r_plot_start <= (w_next == S_GRANT);
      r_busy       <= (w_next != S_IDLE);
      r_req_done   <= (w_next == S_REL) ? r_grant : '0;
      if (w_take) begin
        r_grant <= w_win_oh;
      end else if (r_state == S_REL) begin
        r_grant <= '0;
      end
      if (r_state == S_GRANT) begin
        r_cnt <= '0;
      end else if (r_state == S_BUSY && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_tmo) r_tmo_err <= 1'b1;
    end
  end

`ifdef PLOT_ARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= PW'(N_REQ - 1);
    end else if (w_take) begin
      r_ptr <= w_win_idx;
    end
  end
`endif

  assign grant       = r_grant;
  assign plot_start  = r_plot_start;
  assign req_done    = r_req_done;
  assign busy        = r_busy;
  assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter (N_REQ=4, TIMEOUT_CYC=16).
// Expected grant/req_done values are queued; a monitor pops on outputs.
module tb_plot_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       plot_done;
  logic [3:0] grant;
  logic       plot_start;
  logic [3:0] req_done;
  logic       busy;
  logic       timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] q_grant[$];
  logic [3:0] q_done[$];

  plot_arbiter #(
    .N_REQ(4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .plot_done(plot_done),
    .grant(grant),
    .plot_start(plot_start),
    .req_done(req_done),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compares every plot_start grant and req_done pulse.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (plot_start === 1'b1) begin
        if (q_grant.size() == 0) begin
          chk("unexpected_start", {28'd0, grant}, 32'hdead);
        end else begin
          chk("sb_grant", {28'd0, grant}, {28'd0, q_grant.pop_front()});
        end
      end
      if (req_done !== 4'b0000) begin
        if (q_done.size() == 0) begin
          chk("unexpected_done", {28'd0, req_done}, 32'hdead);
        end else begin
          chk("sb_req_done", {28'd0, req_done}, {28'd0, q_done.pop_front()});
        end
      end
    end
  end

  // One transaction. dly=0 means never send plot_done.
  // n returns negedges from the plot_start cycle to the req_done cycle.
  task automatic serve(input logic [3:0] r, input logic [3:0] eg,
                       input int dly, input bit lat, input bit hold,
                       input int drop_at, output int n);
    int k;
    bit got;
    q_grant.push_back(eg);
    q_done.push_back(eg);
    req = r;
    n = -1;
    if (lat) begin
      @(negedge clk);
      chk("start_latency", {31'd0, plot_start}, 32'd1);
    end
    k = 0;
    while (plot_start !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (plot_start !== 1'b1) begin
      chk("start_wait", {31'd0, plot_start}, 32'd1);
      req = '0;
      return;
    end
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (c == drop_at) req = '0;
      plot_done = (c == dly);
      if (c == dly || (dly == 0 && c == 8))
        chk("grant_hold", {28'd0, grant}, {28'd0, eg});
      if (req_done !== 4'b0000) begin
        got = 1'b1;
        n = c;
      end
    end
    plot_done = 1'b0;
    if (!got) chk("done_wait", 32'd0, 32'd1);
    if (!hold) req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b0;
    req       = '0;
    plot_done = 1'b0;
    cyc(3);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, plot_start}, 32'd0);
    chk("rst_req_done", {28'd0, req_done}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    reset = 1'b1;
    cyc(2);

    // plot_done while idle does nothing
    plot_done = 1'b1;
    @(negedge clk);
    plot_done = 1'b0;
    chk("idle_done_busy", {31'd0, busy}, 32'd0);
    chk("idle_done_start", {31'd0, plot_start}, 32'd0);
    @(negedge clk);
    chk("idle_done_busy2", {31'd0, busy}, 32'd0);

    // Basic: done 10 cycles after start, req_done one later
    serve(4'b0001, 4'b0001, 10, 1, 0, 0, n);
    chk("basic_n", n, 32'd11);
    chk("basic_tmo", {31'd0, timeout_err}, 32'd0);
    cyc(2);
    chk("basic_idle", {31'd0, busy}, 32'd0);

    // Requester drops req mid-BUSY
    serve(4'b0100, 4'b0100, 6, 1, 0, 2, n);
    chk("drop_n", n, 32'd7);
    cyc(2);

    // 0110 -> index 1 in both modes (RR pointer is at 2)
    serve(4'b0110, 4'b0010, 3, 1, 0, 0, n);
    chk("prio_n", n, 32'd4);
    cyc(2);

    // plot_done on the terminal count cycle: no timeout
    serve(4'b0001, 4'b0001, 16, 1, 0, 0, n);
    chk("term_n", n, 32'd17);
    chk("term_tmo", {31'd0, timeout_err}, 32'd0);
    cyc(2);

    // 1010 held for three completions
`ifdef PLOT_ARB_RR_EN
    serve(4'b1010, 4'b0010, 3, 0, 1, 0, n);
    serve(4'b1010, 4'b1000, 3, 0, 1, 0, n);
    serve(4'b1010, 4'b0010, 3, 0, 0, 0, n);
`else
    serve(4'b1010, 4'b0010, 3, 0, 1, 0, n);
    serve(4'b1010, 4'b0010, 3, 0, 1, 0, n);
    serve(4'b1010, 4'b0010, 3, 0, 0, 0, n);
`endif
    chk("b2b_n", n, 32'd4);
    cyc(3);

    // Timeout: 16 BUSY cycles, then RELEASE with sticky error
    serve(4'b0010, 4'b0010, 0, 1, 0, 0, n);
    chk("tmo_n", n, 32'd17);
    chk("tmo_flag", {31'd0, timeout_err}, 32'd1);
    cyc(2);
    serve(4'b1000, 4'b1000, 4, 1, 0, 0, n);
    chk("tmo_sticky_n", n, 32'd5);
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);
    cyc(2);

    // Reset mid-BUSY aborts with no req_done
    q_grant.push_back(4'b0001);
    req = 4'b0001;
    @(negedge clk);
    chk("pre_rst_start", {31'd0, plot_start}, 32'd1);
    cyc(3);
    reset = 1'b0;
    #1;
    chk("mid_rst_grant", {28'd0, grant}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {28'd0, req_done}, 32'd0);
    chk("mid_rst_tmo", {31'd0, timeout_err}, 32'd0);
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    cyc(3);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    serve(4'b0001, 4'b0001, 5, 1, 0, 0, n);
    chk("post_rst_n", n, 32'd6);
    cyc(3);

    chk("q_grant_empty", q_grant.size(), 32'd0);
    chk("q_done_empty", q_done.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
